// File: rtl/aes_pkg.sv
// aes_pkg: constants and types shared by the AES-128 key schedule and the
// round controller.
//   AES_NR          number of rounds for AES-128
//   KEY_W / WORD_W / BYTE_W   key, word and byte widths
//   RCON_INIT       first round constant
//   RCON_POLY       GF(2^8) reduction constant used by xtime
//   aes_state_e     controller state encoding (ST_IDLE, ST_EMIT)
//   xtime()         multiply-by-x in GF(2^8)
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] RCON_INIT = 8'h01;
  localparam logic [BYTE_W-1:0] RCON_POLY = 8'h1b;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } aes_state_e;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: 32-bit SubWord, one sbox per byte, purely combinational.
// Shared with the round datapath's SubBytes.
//   word_in   [31:0]  input word
//   word_out  [31:0]  byte-wise S-box substitution of word_in
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_in,
  output logic [WORD_W-1:0] word_out
);

  for (genvar gi = 0; gi < WORD_W / BYTE_W; gi++) begin : g_byte
    sbox u_sbox (
      .in_byte  (word_in[gi*BYTE_W +: BYTE_W]),
      .out_byte (word_out[gi*BYTE_W +: BYTE_W])
    );
  end

endmodule

// File: rtl/sbox.sv
// sbox: AES forward S-box, purely combinational byte lookup.
//   in_byte   [7:0]  input byte
//   out_byte  [7:0]  substituted byte
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0x00 occupies the most significant byte of the table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a sits at bit offset (255-a)*8 = {~a, 3'b000}.
  logic [10:0] bit_offset;
  assign bit_offset = {~in_byte, 3'b000};
  assign out_byte   = SBOX_TABLE[bit_offset +: 8];

endmodule

// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES-128 key expansion. Produces round keys 0..10
// one per accepted valid/ready transfer, in round order.
//   clk       clock, rising edge
//   reset     synchronous, active-high
//   start     begin expansion of key_in (accepted only when idle)
//   key_in    [127:0] cipher key, w0 in [127:96]
//   rk_ready  consumer accepts the current round key
//   rk_valid  rk_data / rk_round valid
//   rk_data   [127:0] current round key
//   rk_round  [3:0] round index of rk_data
//   busy      from accepted start until round-10 key accepted
//   done      one-cycle pulse after the round-10 key is accepted
//   last_key  [127:0] round-10 key, held until the next accepted start
//             (present only when AES_KEY_SCHED_LAST_KEY_EN is defined)
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              rk_ready,
  output logic              rk_valid,
  output logic [KEY_W-1:0]  rk_data,
  output logic [3:0]        rk_round,
  output logic              busy,
  output logic              done
`ifdef AES_KEY_SCHED_LAST_KEY_EN
  ,
  output logic [KEY_W-1:0]  last_key
`endif
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  aes_state_e          state_reg, state_next;
  logic [KEY_W-1:0]    key_reg, key_next;
  logic [3:0]          round_reg, round_next;
  logic [BYTE_W-1:0]   rcon_reg, rcon_next;
  logic                done_reg, done_next;

  // Next round key from the current one: single-cycle XOR chain.
  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] rot_w3, sub_w3, temp;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .word_in  (rot_w3),
    .word_out (sub_w3)
  );

  assign temp = sub_w3 ^ {rcon_reg, 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  logic handshake;
  logic final_handshake;
  logic start_accept;

  assign handshake       = (state_reg == ST_EMIT) && rk_ready;
  assign final_handshake = handshake && (round_reg == LAST_ROUND);
  assign start_accept    = (state_reg == ST_IDLE) && start;

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    round_next = round_reg;
    rcon_next  = rcon_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          key_next   = key_in;
          round_next = 4'd0;
          rcon_next  = RCON_INIT;
          state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (round_reg == LAST_ROUND) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            key_next   = {n0, n1, n2, n3};
            round_next = round_reg + 4'd1;
            rcon_next  = xtime(rcon_reg);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      key_reg   <= '0;
      round_reg <= 4'd0;
      rcon_reg  <= RCON_INIT;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      round_reg <= round_next;
      rcon_reg  <= rcon_next;
      done_reg  <= done_next;
    end
  end

  assign rk_valid = (state_reg == ST_EMIT);
  assign busy     = (state_reg == ST_EMIT);
  assign rk_data  = key_reg;
  assign rk_round = round_reg;
  assign done     = done_reg;

`ifdef AES_KEY_SCHED_LAST_KEY_EN
  // Round-10 key kept for the decryption path's first AddRoundKey.
  logic [KEY_W-1:0] last_key_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_key_reg <= '0;
    end else if (start_accept) begin
      last_key_reg <= '0;
    end else if (final_handshake) begin
      last_key_reg <= key_reg;
    end
  end

  assign last_key = last_key_reg;
`else
  // Only consumed by the optional last-key register.
  logic unused_ok;
  assign unused_ok = final_handshake ^ start_accept;
`endif

endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: scoreboard bench for aes_key_sched. Stimulus pushes the
// expected round keys; a negedge monitor pops and compares on each handshake
// and checks stability while stalled.
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;
`ifdef AES_KEY_SCHED_LAST_KEY_EN
  logic [127:0] last_key;
`endif

  aes_key_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .busy     (busy),
`ifdef AES_KEY_SCHED_LAST_KEY_EN
    .done     (done),
    .last_key (last_key)
`else
    .done     (done)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int exp_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] data;
    bit           chk;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] fips_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_fips();
    for (int r = 0; r <= 10; r++) sb_q.push_back('{4'(r), fips_rk[r], 1'b1});
  endtask

  task automatic push_zero();
    for (int r = 0; r <= 10; r++) begin
      if (r == 0)       sb_q.push_back('{4'(r), 128'h0, 1'b1});
      else if (r == 1)  sb_q.push_back('{4'(r), ZERO_R1, 1'b1});
      else if (r == 10) sb_q.push_back('{4'(r), ZERO_R10, 1'b1});
      else              sb_q.push_back('{4'(r), 128'h0, 1'b0});
    end
  endtask

  task automatic do_start(input logic [127:0] k);
    @(posedge clk);
    #1;
    start     = 1'b1;
    key_in    = k;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: %0d keys outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: scoreboard pop on handshake, stall stability, done accounting.
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic         prst = 1'b0;
  logic [127:0] pd = '0;
  logic [3:0]   pn = '0;
  exp_t         e;

  initial begin
    forever begin
      @(negedge clk);
      if (pv && !pr && !prst) begin
        check("stall_valid", rk_valid, pv);
        check("stall_data", rk_data, pd);
        check("stall_round", rk_round, pn);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rk_valid && rk_ready && !reset) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_key: round %0d data %h with no key expected", rk_round, rk_data);
        end else begin
          e = sb_q.pop_front();
          check("rk_round", rk_round, e.rnd);
          if (e.chk) check("rk_data", rk_data, e.data);
          $display("[TB] key round %0d data %h", rk_round, rk_data);
        end
      end
      pv   = rk_valid;
      pr   = rk_ready;
      prst = reset;
      pd   = rk_data;
      pn   = rk_round;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rk_ready = 1'b0;
    key_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rk_valid", rk_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rk_data", rk_data, 128'h0);
    check("reset_rk_round", rk_round, 4'd0);
`ifdef AES_KEY_SCHED_LAST_KEY_EN
    check("reset_last_key", last_key, 128'h0);
`endif
    reset = 1'b0;

    // FIPS-197 key, ready tied high.
    rk_ready = 1'b1;
    push_fips();
    do_start(FIPS_KEY);
    check("first_round_valid", rk_valid, 1'b1);
    check("first_round_busy", busy, 1'b1);
    wait_idle("fips");
    exp_done++;
    check("done_latency", 128'(done_cyc - start_cyc), 128'd12);
    check("done_count_fips", 128'(done_cnt), 128'(exp_done));
    $display("[TB] fips run complete");

    // Backpressure with ~30% ready duty.
    rk_ready = 1'b0;
    push_fips();
    do_start(FIPS_KEY);
    for (int i = 0; i < 400; i++) begin
      if (sb_q.size() == 0 && !busy) break;
      rk_ready = ($urandom_range(0, 99) < 30);
      @(posedge clk);
      #1;
    end
    rk_ready = 1'b1;
    wait_idle("backpressure");
    exp_done++;
    check("done_count_bp", 128'(done_cnt), 128'(exp_done));
    $display("[TB] backpressure run complete");

    // Start during EMIT at round 4 must be ignored.
    push_fips();
    do_start(FIPS_KEY);
    repeat (4) @(posedge clk);
    #1;
    check("mid_round", rk_round, 4'd4);
    start  = 1'b1;
    key_in = 128'h00112233445566778899aabbccddeeff;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("start_in_emit");
    exp_done++;
    check("done_count_ign", 128'(done_cnt), 128'(exp_done));
    $display("[TB] ignored-start run complete");

    // Reset while round 6 is presented.
    push_fips();
    do_start(FIPS_KEY);
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_round", rk_round, 4'd6);
    reset    = 1'b1;
    rk_ready = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_valid", rk_valid, 1'b0);
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_round", rk_round, 4'd0);
    check("mid_reset_data", rk_data, 128'h0);
    reset = 1'b0;
    sb_q.delete();
    repeat (3) @(negedge clk);
    check("no_done_after_reset", 128'(done_cnt), 128'(exp_done));
    rk_ready = 1'b1;
    push_fips();
    do_start(FIPS_KEY);
    wait_idle("after_reset");
    exp_done++;
    check("done_count_rst", 128'(done_cnt), 128'(exp_done));
    $display("[TB] reset-restart run complete");

    // Back-to-back: start asserted during the done cycle.
    push_fips();
    push_zero();
    do_start(FIPS_KEY);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      check("b2b_done_seen", seen, 1'b1);
    end
`ifdef AES_KEY_SCHED_LAST_KEY_EN
    check("last_key_hold", last_key, fips_rk[10]);
`endif
    start  = 1'b1;
    key_in = 128'h0;
    @(posedge clk);
    #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    check("b2b_valid", rk_valid, 1'b1);
    check("b2b_round", rk_round, 4'd0);
    wait_idle("back_to_back");
    exp_done += 2;
    check("done_count_b2b", 128'(done_cnt), 128'(exp_done));
`ifdef AES_KEY_SCHED_LAST_KEY_EN
    check("last_key_zero", last_key, ZERO_R10);
`endif
    $display("[TB] back-to-back run complete");

    check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
